// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER ID/EX pipeline register.
// Opcode map, control bundle layout and the bubble encoding live here.
package otter_pipe_pkg;

    localparam logic [31:0] NOP_IR = 32'h00000013;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic [3:0] alu_fun;
        logic [1:0] rf_wr_sel;
        logic       regwrite;
        logic       memwrite;
        logic       memread2;
    } id_ex_ctrl_t;

    // Bubble: no side effects, write-select parked on the ALU path.
    function automatic id_ex_ctrl_t bubble_ctrl();
        id_ex_ctrl_t c;
        c           = '0;
        c.rf_wr_sel = 2'b11;
        return c;
    endfunction

endpackage

// File: rtl/otter_hazard_detect.sv
// Load-use hazard detection: decodes which source operands the ID instruction
// reads and compares them against the destination of a load sitting in EX.
module otter_hazard_detect
    import otter_pipe_pkg::*;
(
    input  logic [6:0] id_opcode_i,
    input  logic       id_funct3_msb_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_valid_i,
    input  logic       ex_valid_i,
    input  logic       ex_memread2_i,
    input  logic [4:0] ex_rd_i,
    output logic       load_use_o
);

    logic rs1_used;
    logic rs2_used;

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_opcode_i)
            OP:                          begin rs1_used = 1'b1; rs2_used = 1'b1; end
            STORE, BRANCH:               begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_IMM, LOAD, JALR:          rs1_used = 1'b1;
            // CSR immediate forms (funct3[2]=1) carry a zimm, not a register.
            SYSTEM:                      rs1_used = ~id_funct3_msb_i;
            default:                     begin rs1_used = 1'b0; rs2_used = 1'b0; end
        endcase
    end

    always_comb begin
        load_use_o = ex_valid_i && ex_memread2_i && (ex_rd_i != 5'd0) && id_valid_i &&
                     ((rs1_used && (id_rs1_i == ex_rd_i)) ||
                      (rs2_used && (id_rs2_i == ex_rd_i)));
    end

endmodule

// File: rtl/otter_id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional macro OTTER_PIPE_PERF_EN adds bubble/flush event counters.
module otter_id_ex_pipe
    import otter_pipe_pkg::*;
#(
    parameter int          XLEN   = 32,
    parameter logic [31:0] NOP_IR = otter_pipe_pkg::NOP_IR
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ID_VALID,
    input  logic [XLEN-1:0] ID_PC,
    input  logic [31:0]     ID_IR,
    input  logic [XLEN-1:0] ID_RS1_DATA,
    input  logic [XLEN-1:0] ID_RS2_DATA,
    input  logic [XLEN-1:0] ID_IMM,
    input  logic            ID_ALU_SRCA,
    input  logic [1:0]      ID_ALU_SRCB,
    input  logic [3:0]      ID_ALU_FUN,
    input  logic [1:0]      ID_RF_WR_SEL,
    input  logic            ID_REGWRITE,
    input  logic            ID_MEMWRITE,
    input  logic            ID_MEMREAD2,
    input  logic            EX_FLUSH,
    input  logic            MEM_STALL,
    output logic            ID_STALL,
    output logic            EX_VALID,
    output logic [XLEN-1:0] EX_PC,
    output logic [XLEN-1:0] EX_RS1_DATA,
    output logic [XLEN-1:0] EX_RS2_DATA,
    output logic [XLEN-1:0] EX_IMM,
    output logic [31:0]     EX_IR,
    output logic            EX_ALU_SRCA,
    output logic [1:0]      EX_ALU_SRCB,
    output logic [3:0]      EX_ALU_FUN,
    output logic [1:0]      EX_RF_WR_SEL,
    output logic            EX_REGWRITE,
    output logic            EX_MEMWRITE,
    output logic            EX_MEMREAD2
`ifdef OTTER_PIPE_PERF_EN
    ,
    output logic [XLEN-1:0] PERF_BUBBLES,
    output logic [XLEN-1:0] PERF_FLUSHES
`endif
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [31:0]     ir_q, ir_d;
    id_ex_ctrl_t     ctrl_q, ctrl_d;
    id_ex_ctrl_t     id_ctrl;
    logic            load_use;
    logic            do_hold;
    logic            do_bubble;

    otter_hazard_detect u_hazard (
        .id_opcode_i     (ID_IR[6:0]),
        .id_funct3_msb_i (ID_IR[14]),
        .id_rs1_i        (ID_IR[19:15]),
        .id_rs2_i        (ID_IR[24:20]),
        .id_valid_i      (ID_VALID),
        .ex_valid_i      (valid_q),
        .ex_memread2_i   (ctrl_q.memread2),
        .ex_rd_i         (ir_q[11:7]),
        .load_use_o      (load_use)
    );

    // Stall protocol: ID_STALL=1 means IF/ID and PC must not advance this
    // cycle. A flush overrides everything below reset; MEM_STALL beats hazard.
    always_comb begin
        do_hold   = !EX_FLUSH && MEM_STALL;
        do_bubble = EX_FLUSH || (!MEM_STALL && load_use);
        ID_STALL  = RST_N && !EX_FLUSH && (MEM_STALL || load_use);
    end

    always_comb begin
        id_ctrl.alu_srca  = ID_ALU_SRCA;
        id_ctrl.alu_srcb  = ID_ALU_SRCB;
        id_ctrl.alu_fun   = ID_ALU_FUN;
        id_ctrl.rf_wr_sel = ID_RF_WR_SEL;
        id_ctrl.regwrite  = ID_REGWRITE && ID_VALID;
        id_ctrl.memwrite  = ID_MEMWRITE && ID_VALID;
        id_ctrl.memread2  = ID_MEMREAD2 && ID_VALID;
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        ir_d    = ir_q;
        ctrl_d  = ctrl_q;
        if (do_hold) begin
            valid_d = valid_q;
        end else if (do_bubble) begin
            valid_d = 1'b0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            imm_d   = '0;
            ir_d    = NOP_IR;
            ctrl_d  = bubble_ctrl();
        end else begin
            valid_d = ID_VALID;
            pc_d    = ID_PC;
            rs1_d   = ID_RS1_DATA;
            rs2_d   = ID_RS2_DATA;
            imm_d   = ID_IMM;
            ir_d    = ID_IR;
            ctrl_d  = id_ctrl;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            ir_q    <= NOP_IR;
            ctrl_q  <= bubble_ctrl();
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign EX_VALID     = valid_q;
    assign EX_PC        = pc_q;
    assign EX_RS1_DATA  = rs1_q;
    assign EX_RS2_DATA  = rs2_q;
    assign EX_IMM       = imm_q;
    assign EX_IR        = ir_q;
    assign EX_ALU_SRCA  = ctrl_q.alu_srca;
    assign EX_ALU_SRCB  = ctrl_q.alu_srcb;
    assign EX_ALU_FUN   = ctrl_q.alu_fun;
    assign EX_RF_WR_SEL = ctrl_q.rf_wr_sel;
    assign EX_REGWRITE  = ctrl_q.regwrite;
    assign EX_MEMWRITE  = ctrl_q.memwrite;
    assign EX_MEMREAD2  = ctrl_q.memread2;

`ifdef OTTER_PIPE_PERF_EN
    logic [XLEN-1:0] perf_bubbles_q, perf_bubbles_d;
    logic [XLEN-1:0] perf_flushes_q, perf_flushes_d;

    always_comb begin
        perf_bubbles_d = perf_bubbles_q;
        perf_flushes_d = perf_flushes_q;
        if (EX_FLUSH) begin
            perf_flushes_d = perf_flushes_q + 1'b1;
        end else if (do_bubble) begin
            perf_bubbles_d = perf_bubbles_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perf_bubbles_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_bubbles_q <= perf_bubbles_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign PERF_BUBBLES = perf_bubbles_q;
    assign PERF_FLUSHES = perf_flushes_q;
`endif

endmodule

// File: tb/tb_otter_id_ex_pipe.sv
// Directed, table-driven bench for otter_id_ex_pipe (OTTER_PIPE_PERF_EN aware).
module tb_otter_id_ex_pipe;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADD3  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] LW5   = 32'h00052283; // lw  x5,0(x10)
    localparam logic [31:0] ADD6  = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] LW0   = 32'h00052003; // lw  x0,0(x10)
    localparam logic [31:0] ADD00 = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] LUI5  = 32'h123452B7; // lui x5,0x12345
    localparam logic [31:0] SW5   = 32'h00512223; // sw  x5,4(x2)

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ID_VALID;
    logic [31:0] ID_PC, ID_IR, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
    logic        ID_ALU_SRCA;
    logic [1:0]  ID_ALU_SRCB;
    logic [3:0]  ID_ALU_FUN;
    logic [1:0]  ID_RF_WR_SEL;
    logic        ID_REGWRITE, ID_MEMWRITE, ID_MEMREAD2;
    logic        EX_FLUSH, MEM_STALL;
    logic        ID_STALL, EX_VALID;
    logic [31:0] EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM, EX_IR;
    logic        EX_ALU_SRCA;
    logic [1:0]  EX_ALU_SRCB;
    logic [3:0]  EX_ALU_FUN;
    logic [1:0]  EX_RF_WR_SEL;
    logic        EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD2;
`ifdef OTTER_PIPE_PERF_EN
    logic [31:0] PERF_BUBBLES, PERF_FLUSHES;
`endif

    int checks = 0;
    int errors = 0;

    otter_id_ex_pipe #(.XLEN(32), .NOP_IR(32'h00000013)) dut (
        .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .ID_PC(ID_PC), .ID_IR(ID_IR),
        .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
        .ID_ALU_SRCA(ID_ALU_SRCA), .ID_ALU_SRCB(ID_ALU_SRCB), .ID_ALU_FUN(ID_ALU_FUN),
        .ID_RF_WR_SEL(ID_RF_WR_SEL), .ID_REGWRITE(ID_REGWRITE), .ID_MEMWRITE(ID_MEMWRITE),
        .ID_MEMREAD2(ID_MEMREAD2), .EX_FLUSH(EX_FLUSH), .MEM_STALL(MEM_STALL),
        .ID_STALL(ID_STALL), .EX_VALID(EX_VALID), .EX_PC(EX_PC),
        .EX_RS1_DATA(EX_RS1_DATA), .EX_RS2_DATA(EX_RS2_DATA), .EX_IMM(EX_IMM), .EX_IR(EX_IR),
        .EX_ALU_SRCA(EX_ALU_SRCA), .EX_ALU_SRCB(EX_ALU_SRCB), .EX_ALU_FUN(EX_ALU_FUN),
        .EX_RF_WR_SEL(EX_RF_WR_SEL), .EX_REGWRITE(EX_REGWRITE), .EX_MEMWRITE(EX_MEMWRITE),
        .EX_MEMREAD2(EX_MEMREAD2)
`ifdef OTTER_PIPE_PERF_EN
        , .PERF_BUBBLES(PERF_BUBBLES), .PERF_FLUSHES(PERF_FLUSHES)
`endif
    );

    // Clock / reset block
    always #5 CLK = ~CLK;

    // Control bundle: {srca, srcb[1:0], fun[3:0], rf_wr_sel[1:0], regwrite, memwrite, memread2}
    function automatic logic [11:0] mk_ctrl(logic a, logic [1:0] b, logic [3:0] f,
                                            logic [1:0] s, logic rw, logic mw, logic mr);
        return {a, b, f, s, rw, mw, mr};
    endfunction

    typedef struct {
        logic        rst_n, id_valid, flush, mem_stall;
        logic [31:0] pc, ir;
        logic [11:0] ctrl;
        logic        exp_stall, exp_valid;
        logic [31:0] exp_pc, exp_ir;
        logic [11:0] exp_ctrl;
    } vec_t;

    function automatic vec_t mkv(logic r, logic v, logic fl, logic ms, logic [31:0] pc,
                                 logic [31:0] ir, logic [11:0] c, logic es, logic ev,
                                 logic [31:0] epc, logic [31:0] eir, logic [11:0] ec);
        vec_t t;
        t.rst_n = r; t.id_valid = v; t.flush = fl; t.mem_stall = ms;
        t.pc = pc; t.ir = ir; t.ctrl = c;
        t.exp_stall = es; t.exp_valid = ev; t.exp_pc = epc; t.exp_ir = eir; t.exp_ctrl = ec;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver: drive on the falling edge, check ID_STALL before the rising
    // edge and the EX register just after it.
    task automatic apply(vec_t t, int idx);
        logic [31:0] exp_data;
        @(negedge CLK);
        RST_N = t.rst_n; ID_VALID = t.id_valid; EX_FLUSH = t.flush; MEM_STALL = t.mem_stall;
        ID_PC = t.pc; ID_IR = t.ir;
        ID_RS1_DATA = t.pc + 32'h1000; ID_RS2_DATA = t.pc + 32'h2000; ID_IMM = t.pc + 32'h3000;
        {ID_ALU_SRCA, ID_ALU_SRCB, ID_ALU_FUN, ID_RF_WR_SEL,
         ID_REGWRITE, ID_MEMWRITE, ID_MEMREAD2} = t.ctrl;
        #1;
        check($sformatf("v%0d id_stall", idx), {31'd0, ID_STALL}, {31'd0, t.exp_stall});
        @(posedge CLK);
        #1;
        check($sformatf("v%0d ex_valid", idx), {31'd0, EX_VALID}, {31'd0, t.exp_valid});
        check($sformatf("v%0d ex_pc", idx), EX_PC, t.exp_pc);
        check($sformatf("v%0d ex_ir", idx), EX_IR, t.exp_ir);
        check($sformatf("v%0d ex_ctrl", idx),
              {20'd0, EX_ALU_SRCA, EX_ALU_SRCB, EX_ALU_FUN, EX_RF_WR_SEL,
               EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD2}, {20'd0, t.exp_ctrl});
        exp_data = (t.exp_pc == 32'd0) ? 32'd0 : t.exp_pc + 32'h1000;
        check($sformatf("v%0d ex_rs1", idx), EX_RS1_DATA, exp_data);
        exp_data = (t.exp_pc == 32'd0) ? 32'd0 : t.exp_pc + 32'h2000;
        check($sformatf("v%0d ex_rs2", idx), EX_RS2_DATA, exp_data);
        exp_data = (t.exp_pc == 32'd0) ? 32'd0 : t.exp_pc + 32'h3000;
        check($sformatf("v%0d ex_imm", idx), EX_IMM, exp_data);
        if (!EX_VALID) begin
            check($sformatf("v%0d no_side_effects", idx),
                  {29'd0, EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD2}, 32'd0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [11:0] c_add, c_lw, c_lui, c_sw, c_bub, c_add_inv;
        c_add     = mk_ctrl(1'b0, 2'd0, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);
        c_lw      = mk_ctrl(1'b0, 2'd1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b1);
        c_lui     = mk_ctrl(1'b1, 2'd0, 4'b1001, 2'd3, 1'b1, 1'b0, 1'b0);
        c_sw      = mk_ctrl(1'b0, 2'd2, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        c_bub     = mk_ctrl(1'b0, 2'd0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
        c_add_inv = mk_ctrl(1'b0, 2'd0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);

        RST_N = 1'b0; ID_VALID = 1'b0; EX_FLUSH = 1'b0; MEM_STALL = 1'b0;
        ID_PC = '0; ID_IR = NOP; ID_RS1_DATA = '0; ID_RS2_DATA = '0; ID_IMM = '0;
        {ID_ALU_SRCA, ID_ALU_SRCB, ID_ALU_FUN, ID_RF_WR_SEL,
         ID_REGWRITE, ID_MEMWRITE, ID_MEMREAD2} = '0;

        //                 rst vld fl ms  pc       ir     ctrl       stl ev exp_pc   exp_ir exp_ctrl
        vecs.push_back(mkv(0, 1, 0, 0, 32'h100, ADD3,  c_add,  0, 0, 32'h0,   NOP,   c_bub));
        vecs.push_back(mkv(0, 1, 0, 0, 32'h100, ADD3,  c_add,  0, 0, 32'h0,   NOP,   c_bub));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h100, ADD3,  c_add,  0, 1, 32'h100, ADD3,  c_add));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h104, LW5,   c_lw,   0, 1, 32'h104, LW5,   c_lw));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h108, ADD6,  c_add,  1, 0, 32'h0,   NOP,   c_bub));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h108, ADD6,  c_add,  0, 1, 32'h108, ADD6,  c_add));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h10C, LW0,   c_lw,   0, 1, 32'h10C, LW0,   c_lw));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h110, ADD00, c_add,  0, 1, 32'h110, ADD00, c_add));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h114, LW5,   c_lw,   0, 1, 32'h114, LW5,   c_lw));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h118, LUI5,  c_lui,  0, 1, 32'h118, LUI5,  c_lui));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h11C, LW5,   c_lw,   0, 1, 32'h11C, LW5,   c_lw));
        vecs.push_back(mkv(1, 1, 1, 0, 32'h120, ADD6,  c_add,  0, 0, 32'h0,   NOP,   c_bub));
        vecs.push_back(mkv(1, 0, 0, 0, 32'h120, ADD6,  c_add,  0, 0, 32'h120, ADD6,  c_add_inv));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h124, SW5,   c_sw,   0, 1, 32'h124, SW5,   c_sw));
        vecs.push_back(mkv(1, 1, 0, 1, 32'h128, ADD6,  c_add,  1, 1, 32'h124, SW5,   c_sw));
        vecs.push_back(mkv(1, 1, 0, 1, 32'h128, ADD6,  c_add,  1, 1, 32'h124, SW5,   c_sw));
        vecs.push_back(mkv(1, 1, 0, 1, 32'h128, ADD6,  c_add,  1, 1, 32'h124, SW5,   c_sw));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h128, ADD6,  c_add,  0, 1, 32'h128, ADD6,  c_add));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h12C, LW5,   c_lw,   0, 1, 32'h12C, LW5,   c_lw));
        vecs.push_back(mkv(1, 1, 0, 1, 32'h130, ADD6,  c_add,  1, 1, 32'h12C, LW5,   c_lw));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h130, ADD6,  c_add,  1, 0, 32'h0,   NOP,   c_bub));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h130, ADD6,  c_add,  0, 1, 32'h130, ADD6,  c_add));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h134, LW5,   c_lw,   0, 1, 32'h134, LW5,   c_lw));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h138, SW5,   c_sw,   1, 0, 32'h0,   NOP,   c_bub));
        vecs.push_back(mkv(1, 1, 0, 0, 32'h138, SW5,   c_sw,   0, 1, 32'h138, SW5,   c_sw));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Flush together with MEM_STALL and a live hazard: the flush wins.
        apply(mkv(1, 1, 0, 0, 32'h140, LW5, c_lw, 0, 1, 32'h140, LW5, c_lw), 100);
        apply(mkv(1, 1, 1, 1, 32'h144, ADD6, c_add, 0, 0, 32'h0, NOP, c_bub), 101);
        apply(mkv(1, 1, 0, 0, 32'h144, ADD6, c_add, 0, 1, 32'h144, ADD6, c_add), 102);

`ifdef OTTER_PIPE_PERF_EN
        check("perf_bubbles", PERF_BUBBLES, 32'd3);
        check("perf_flushes", PERF_FLUSHES, 32'd2);
`endif

        // Mid-stream reset with a load in EX and a dependent instruction in ID.
        apply(mkv(1, 1, 0, 0, 32'h148, LW5, c_lw, 0, 1, 32'h148, LW5, c_lw), 103);
        apply(mkv(0, 1, 0, 0, 32'h14C, ADD6, c_add, 0, 0, 32'h0, NOP, c_bub), 104);
`ifdef OTTER_PIPE_PERF_EN
        check("perf_bubbles_rst", PERF_BUBBLES, 32'd0);
        check("perf_flushes_rst", PERF_FLUSHES, 32'd0);
`endif
        apply(mkv(1, 1, 0, 0, 32'h14C, ADD6, c_add, 0, 1, 32'h14C, ADD6, c_add), 105);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otter_id_ex_pipe.md
Name: otter_id_ex_pipe

Overview:
- ID/EX pipeline register for the OTTER pipelined core.
- Captures the decoder's control outputs, register operands, immediate, PC and IR at the end of ID and presents them to EX.
- Owns load-use hazard detection: inserts a one-cycle bubble into EX and holds IF/ID.
- Honours EX redirect flushes and downstream memory back-pressure.

Parameters:
- XLEN, 32, datapath width for PC, operands and immediate.
- NOP_IR, 32'h00000013, IR value loaded on reset, flush or bubble (addi x0,x0,0).

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- ID_VALID  in  1  ID holds a real instruction.
- ID_PC  in  XLEN  PC of the ID instruction.
- ID_IR  in  32  instruction word; opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- ID_RS1_DATA, ID_RS2_DATA  in  XLEN  register-file read data.
- ID_IMM  in  XLEN  immediate selected by the ID immediate generator.
- ID_ALU_SRCA  in  1 / ID_ALU_SRCB  in  2 / ID_ALU_FUN  in  4 / ID_RF_WR_SEL  in  2 / ID_REGWRITE, ID_MEMWRITE, ID_MEMREAD2  in  1 each  decoder controls.
- EX_FLUSH  in  1  EX redirect (taken branch, jump, mret); kills the ID instruction.
- MEM_STALL  in  1  downstream stall; the whole ID/EX register holds.
- ID_STALL  out  1  combinational; IF/ID and PC must hold this cycle.
- EX_VALID  out  1  registered.
- EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM  out  XLEN  registered.
- EX_IR  out  32  registered.
- EX_ALU_SRCA, EX_ALU_SRCB, EX_ALU_FUN, EX_RF_WR_SEL, EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD2  out  (widths as ID)  registered.

Behaviour:
- Reset (RST_N=0 at an edge):
  - EX_VALID=0, EX_IR=NOP_IR, EX_RF_WR_SEL=3.
  - All other EX_* outputs are 0.
  - ID_STALL is forced to 0 while RST_N=0.
- Operand use, decoded from ID_IR opcode:
  - rs1 used by OP, OP_IMM, LOAD, STORE, BRANCH, JALR and SYSTEM when func3[2]=0.
  - rs2 used by OP, STORE and BRANCH.
  - LUI, AUIPC and JAL use neither operand.
- Load-use hazard (combinational) fires when all of the following hold:
  - EX_VALID and EX_MEMREAD2;
  - EX_IR[11:7] != 0;
  - ID_VALID;
  - EX rd equals a used rs1 or used rs2.
- Per-edge priority (highest first):
  1. Reset.
  2. EX_FLUSH: load a bubble (EX_VALID=0, IR=NOP_IR, REGWRITE/MEMWRITE/MEMREAD2=0, RF_WR_SEL=3); ID_STALL=0.
  3. MEM_STALL: every EX_* register holds; ID_STALL=1.
  4. Hazard: load a bubble; ID_STALL=1.
  5. Normal: capture all ID_* values; EX_VALID=ID_VALID. If ID_VALID=0, REGWRITE/MEMWRITE/MEMREAD2 are captured as 0.
- Latency: 1 cycle from ID to EX.
- A load-use hazard costs exactly 1 bubble: the bubble clears EX_MEMREAD2, so the hazard drops the next cycle.
- Loads to x0 never stall.
- If MEM_STALL and the hazard are both active, the register holds. The hazard is re-evaluated when MEM_STALL drops.
- Side-effect controls (REGWRITE, MEMWRITE, MEMREAD2) are never 1 while EX_VALID=0.

Optional Feature:
- Macro OTTER_PIPE_PERF_EN.
- Defined: adds outputs PERF_BUBBLES and PERF_FLUSHES, both XLEN wide and registered.
  - Each counts edges where hazard bubbles or flushes were applied.
  - Cleared by reset; wraps at 2^XLEN-1 to 0.
  - Not incremented on MEM_STALL hold edges.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package otter_pipe_pkg holds:
  - opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM);
  - NOP_IR constant;
  - packed struct id_ex_ctrl_t (alu_srca, alu_srcb, alu_fun, rf_wr_sel, regwrite, memwrite, memread2);
  - function bubble_ctrl() returning the bubble encoding.
- One sub-module, otter_hazard_detect: combinational operand-use decode plus the load-use compare. Output: load_use.

Test Plan:
- Reset: RST_N=0 for 2 edges with ID_VALID=1 -> EX_VALID=0, EX_IR=32'h13, EX_REGWRITE=0, ID_STALL=0.
- Pass-through: add x3,x1,x2 at PC 0x100 -> next edge EX_PC=0x100, EX_ALU_FUN=4'b0000, EX_REGWRITE=1, EX_VALID=1.
- Load-use: lw x5 in EX, then add x6,x5,x7 in ID -> ID_STALL=1 for 1 cycle, one bubble (EX_VALID=0), then add enters EX. Same with lw x0 -> no stall.
- No false hazard: lw x5 in EX, then lui x5 in ID -> no stall.
- Flush vs hazard: EX_FLUSH=1 with hazard active -> bubble, ID_STALL=0.
- MEM_STALL=1 for 3 cycles with sw in EX -> EX_* unchanged, EX_MEMWRITE stays 1, ID_STALL=1; with OTTER_PIPE_PERF_EN, counters unchanged during the hold.
